frame_sched: RTL and testbench
==============================

FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16: words per output frame (power of 2, 4..256).
REQ-002 SHALL have parameter STATUS_INTERVAL, default 64: trace frames sent before a status frame is forced (1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port traceAvail  input  1  trace word available from packet marshaller.
REQ-006 SHALL have port traceWd  input  16  current trace word; valid while traceAvail=1.
REQ-007 SHALL have port traceNext  output  1  one-cycle pulse; trace word consumed.
REQ-008 SHALL have port sync  input  1  trace decoder in-sync level.
REQ-009 SHALL have port ovf  input  1  one-cycle pulse per marshaller overflow event.
REQ-010 SHALL have port frameReset  input  1  host resync request, level, synchronous to clk.
REQ-011 SHALL have port txFree  input  1  SPI transmitter can accept a word this cycle.
REQ-012 SHALL have port txValid  output  1  txWord valid for the transmitter.
REQ-013 SHALL have port txWord  output  16  word offered to the transmitter.
REQ-014 SHALL have port inStatus  output  1  high while a status frame is in progress.

Function
REQ-015 SHALL implement states IDLE (frame boundary), TRACE, STATUS.
REQ-016 Transfer SHALL occur on any edge where txValid=1 and txFree=1; one word per transfer, back-to-back transfers permitted every cycle.
REQ-017 In TRACE: txValid=traceAvail, txWord=traceWd, both combinational; traceNext=transfer.
REQ-018 In STATUS: txValid=1; txWord by word index: 0 -> 16'hA55A; 1 -> {sync,15'b0}; 2 -> ovf snapshot; 3 -> status sequence number; 4..FRAME_LEN-1 -> 16'h0000.
REQ-019 In IDLE: txValid=0, traceNext=0, txWord=16'h0000.
REQ-020 IDLE decision, evaluated each cycle with frameReset=0, priority order: sinceStatus>=STATUS_INTERVAL -> STATUS; traceAvail=1 -> TRACE; txFree=1 -> STATUS (filler); else stay IDLE.
REQ-021 The first word of a frame SHALL be offered the cycle after leaving IDLE (decision latency 1 cycle).
REQ-022 Word counter (log2 FRAME_LEN bits) SHALL clear on frame start and increment per transfer; transfer of word FRAME_LEN-1 returns to IDLE on the same edge.
REQ-023 A trace frame SHALL NOT be abandoned when traceAvail drops mid-frame; it stalls with txValid=0 until data resumes.
REQ-024 sinceStatus (8-bit) SHALL increment at completion of each trace frame, saturating at 255, and clear at start of each status frame.
REQ-025 ovfCount (16-bit) SHALL increment per ovf pulse, saturating at 16'hFFFF; at status frame start it is snapshotted into word 2 and cleared; an ovf pulse on the snapshot edge leaves ovfCount=1.
REQ-026 Status sequence number (16-bit) SHALL increment at completion of each status frame, wrapping FFFF->0000.
REQ-027 frameReset=1 SHALL, on each edge while asserted, force IDLE, clear word counter, suppress traceNext and txValid combinationally, and set sinceStatus to STATUS_INTERVAL so the first frame after release is a status frame; ovfCount and sequence number are unchanged.
REQ-028 frameReset SHALL take precedence over transfer and frame completion in the same cycle; a word offered in that cycle is not counted as consumed.
REQ-029 inStatus SHALL equal (state==STATUS).

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, word counter=0, sinceStatus=STATUS_INTERVAL, ovfCount=0, sequence=0, snapshot=0.
REQ-031 During and after reset, until the first decision: txValid=0, traceNext=0, txWord=16'h0000, inStatus=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; no partial frame resumes after release.

Verification
REQ-033 Reset release, txFree=1, traceAvail=0 -> status frame first: A55A, {sync,0}, 0000, 0000, then zeros; sequence 1 on next status frame.
REQ-034 STATUS_INTERVAL=2, traceAvail and txFree held 1 -> order status, trace, trace, status; 16 traceNext pulses per trace frame; txWord equals traceWd each transfer.
REQ-035 traceAvail dropped for 5 cycles at word 7 of a trace frame -> txValid=0 for 5 cycles, no IDLE entry, frame completes with exactly 16 transfers.
REQ-036 3 ovf pulses, then 1 pulse coincident with status frame start -> word 2 = 0003; next status frame word 2 = 0001; 70000 pulses -> FFFF.
REQ-037 frameReset asserted at word 9 of a trace frame for 2 cycles -> txValid=0 and traceNext=0 immediately, IDLE, next frame status with sequence unchanged.
REQ-038 txFree toggling 1/0 each cycle during a status frame -> each word held stable until accepted, 16 transfers, no word skipped or repeated.

Source files
------------

// File: rtl/frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : frame_sched
// Purpose  : Builds fixed-length output frames for an SPI transmitter. Each
//            frame is either a trace frame (words passed through from the
//            packet marshaller) or a status frame (marker, sync flag, overflow
//            snapshot, sequence number, zero padding). A status frame is
//            forced after STATUS_INTERVAL trace frames and is also sent as
//            filler whenever the transmitter is idle and no trace data waits.
// Ports    : clk        - sole clock, rising edge
//            rst        - asynchronous active-low reset
//            traceAvail - trace word available
//            traceWd    - current trace word
//            traceNext  - pulse: trace word consumed
//            sync       - decoder in-sync level, reported in status word 1
//            ovf        - marshaller overflow pulse
//            frameReset - host resync request (level, synchronous)
//            txFree     - transmitter accepts a word this cycle
//            txValid    - txWord is valid
//            txWord     - word offered to the transmitter
//            inStatus   - high while a status frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module frame_sched #(
  parameter int FRAME_LEN       = 16,
  parameter int STATUS_INTERVAL = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        traceAvail,
  input  logic [15:0] traceWd,
  output logic        traceNext,
  input  logic        sync,
  input  logic        ovf,
  input  logic        frameReset,
  input  logic        txFree,
  output logic        txValid,
  output logic [15:0] txWord,
  output logic        inStatus
);

  localparam int c_CNT_W = $clog2(FRAME_LEN);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_TRACE  = 2'd1;
  localparam logic [1:0] c_STATUS = 2'd2;

  localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(FRAME_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_IDX_MARK = c_CNT_W'(0);
  localparam logic [c_CNT_W-1:0] c_IDX_SYNC = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_IDX_OVF  = c_CNT_W'(2);
  localparam logic [c_CNT_W-1:0] c_IDX_SEQ  = c_CNT_W'(3);
  localparam logic [7:0]         c_INTERVAL = 8'(STATUS_INTERVAL);
  localparam logic [15:0]        c_MARKER   = 16'hA55A;

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [c_CNT_W-1:0] r_wordCnt;
  logic [7:0]         r_sinceStatus;
  logic [15:0]        r_ovfCount;
  logic [15:0]        r_ovfSnap;
  logic [15:0]        r_seqNum;

  logic w_transfer;
  logic w_frameDone;
  logic w_startStatus;

  // txValid is already forced low under frameReset, so a word offered in a
  // resync cycle never counts as transferred.
  assign w_transfer    = txValid & txFree;
  assign w_frameDone   = w_transfer & (r_wordCnt == c_LAST);
  assign w_startStatus = (r_state == c_IDLE) & (w_nextState == c_STATUS);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    if (frameReset) begin
      w_nextState = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (r_sinceStatus >= c_INTERVAL) begin
            w_nextState = c_STATUS;
          end else if (traceAvail) begin
            w_nextState = c_TRACE;
          end else if (txFree) begin
            w_nextState = c_STATUS;   // filler keeps the link busy
          end
        end
        c_TRACE, c_STATUS: begin
          if (w_frameDone) begin
            w_nextState = c_IDLE;
          end
        end
        default: w_nextState = c_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    txValid   = 1'b0;
    traceNext = 1'b0;
    txWord    = 16'h0000;
    inStatus  = 1'b0;
    case (r_state)
      c_TRACE: begin
        // A trace frame stalls rather than aborting when data runs dry.
        txValid   = traceAvail & ~frameReset;
        traceNext = traceAvail & ~frameReset & txFree;
        txWord    = traceWd;
      end
      c_STATUS: begin
        inStatus = 1'b1;
        txValid  = ~frameReset;
        case (r_wordCnt)
          c_IDX_MARK: txWord = c_MARKER;
          c_IDX_SYNC: txWord = {sync, 15'b0};
          c_IDX_OVF:  txWord = r_ovfSnap;
          c_IDX_SEQ:  txWord = r_seqNum;
          default:    txWord = 16'h0000;
        endcase
      end
      default: ;
    endcase
  end

  // Frame bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wordCnt     <= '0;
      r_sinceStatus <= c_INTERVAL;
      r_ovfCount    <= 16'h0000;
      r_ovfSnap     <= 16'h0000;
      r_seqNum      <= 16'h0000;
    end else if (frameReset) begin
      // Resync: drop the frame and make the first one after release a status
      // frame. Overflow accounting and sequence number survive.
      r_wordCnt     <= '0;
      r_sinceStatus <= c_INTERVAL;
      if (ovf && (r_ovfCount != 16'hFFFF)) begin
        r_ovfCount <= r_ovfCount + 16'd1;
      end
    end else begin
      if (r_state == c_IDLE) begin
        r_wordCnt <= '0;
      end else if (w_transfer) begin
        r_wordCnt <= r_wordCnt + 1'b1;   // wraps to 0 on the last word
      end

      if (w_startStatus) begin
        r_sinceStatus <= 8'd0;
      end else if ((r_state == c_TRACE) && w_frameDone && (r_sinceStatus != 8'hFF)) begin
        r_sinceStatus <= r_sinceStatus + 8'd1;
      end

      // A pulse coinciding with the snapshot belongs to the next interval.
      if (w_startStatus) begin
        r_ovfSnap  <= r_ovfCount;
        r_ovfCount <= {15'b0, ovf};
      end else if (ovf && (r_ovfCount != 16'hFFFF)) begin
        r_ovfCount <= r_ovfCount + 16'd1;
      end

      if ((r_state == c_STATUS) && w_frameDone) begin
        r_seqNum <= r_seqNum + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sched
// Purpose  : Self-checking bench for frame_sched (FRAME_LEN=16,
//            STATUS_INTERVAL=2) against a behavioural frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sched;

  localparam int FL = 16;
  localparam int SI = 2;

  logic        clk, rst, traceAvail, sync, ovf, frameReset, txFree;
  logic [15:0] traceWd;
  logic        traceNext, txValid, inStatus;
  logic [15:0] txWord;

  int checks = 0;
  int errors = 0;

  // Behavioural model: frame kind (0 none, 1 trace, 2 status) and position.
  int mKind, mIdx, mSince, mOvf, mSnap, mSeq;
  logic        eValid, eNext, eStat;
  logic [15:0] eWord;

  frame_sched #(.FRAME_LEN(FL), .STATUS_INTERVAL(SI)) dut (
    .clk(clk), .rst(rst), .traceAvail(traceAvail), .traceWd(traceWd),
    .traceNext(traceNext), .sync(sync), .ovf(ovf), .frameReset(frameReset),
    .txFree(txFree), .txValid(txValid), .txWord(txWord), .inStatus(inStatus)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mKind = 0; mIdx = 0; mSince = SI; mOvf = 0; mSnap = 0; mSeq = 0;
  endtask

  task automatic modelOut();
    eValid = 1'b0; eNext = 1'b0; eStat = 1'b0; eWord = 16'h0000;
    if (mKind == 1) begin
      eValid = traceAvail && !frameReset;
      eNext  = eValid && txFree;
      eWord  = traceWd;
    end else if (mKind == 2) begin
      eStat  = 1'b1;
      eValid = !frameReset;
      if (mIdx == 0)      eWord = 16'hA55A;
      else if (mIdx == 1) eWord = sync ? 16'h8000 : 16'h0000;
      else if (mIdx == 2) eWord = mSnap[15:0];
      else if (mIdx == 3) eWord = mSeq[15:0];
    end
  endtask

  task automatic modelEdge();
    bit xfer;
    modelOut();
    xfer = eValid && txFree;
    if (frameReset) begin
      mKind = 0; mIdx = 0; mSince = SI;
      if (ovf && mOvf < 65535) mOvf++;
      return;
    end
    if (mKind == 0) begin
      if (mSince >= SI || (!traceAvail && txFree)) begin
        mKind = 2; mIdx = 0; mSince = 0; mSnap = mOvf; mOvf = ovf ? 1 : 0;
        return;
      end else if (traceAvail) begin
        mKind = 1; mIdx = 0;
      end
    end else if (xfer) begin
      mIdx++;
      if (mIdx == FL) begin
        if (mKind == 1) mSince = (mSince < 255) ? mSince + 1 : 255;
        else            mSeq = (mSeq + 1) % 65536;
        mKind = 0; mIdx = 0;
      end
    end
    if (ovf && mOvf < 65535) mOvf++;
  endtask

  // One clock: model follows the DUT edge, returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) modelReset(); else modelEdge();
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b0; traceAvail = 0; traceWd = 0; sync = 0; ovf = 0;
    frameReset = 0; txFree = 0;
    modelReset();
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic waitModel(input int k, input int i, input string nm);
    int n = 0;
    while (!(mKind == k && mIdx == i) && n < 300) begin tick(); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL %s: wait expired, kind %0d idx %0d", nm, mKind, mIdx); end
  endtask

  task automatic test_reset();
    rst = 1'b0; traceAvail = 1; txFree = 1; frameReset = 0; ovf = 0; sync = 1; traceWd = 16'h1234;
    modelReset();
    #1;
    checks++; if (txValid !== 1'b0)   begin errors++; $display("FAIL reset_txValid: got %b expected 0", txValid); end
    checks++; if (traceNext !== 1'b0) begin errors++; $display("FAIL reset_traceNext: got %b expected 0", traceNext); end
    checks++; if (txWord !== 16'h0)   begin errors++; $display("FAIL reset_txWord: got %h expected 0000", txWord); end
    checks++; if (inStatus !== 1'b0)  begin errors++; $display("FAIL reset_inStatus: got %b expected 0", inStatus); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if ({txValid, traceNext, inStatus, txWord} !== 19'h0)
      begin errors++; $display("FAIL release_idle: got v%b n%b s%b w%h expected all zero", txValid, traceNext, inStatus, txWord); end
    tick(); #1;
    checks++; if (inStatus !== 1'b1 || txWord !== 16'hA55A)
      begin errors++; $display("FAIL first_frame_status: got s%b w%h expected s1 wA55A", inStatus, txWord); end
  endtask

  task automatic test_status_first();
    logic [15:0] words[FL];
    int n = 0;
    int c = 0;
    applyReset();
    txFree = 1; traceAvail = 0; sync = 1;
    while (n < FL && c < 60) begin
      #1; modelOut(); checks++;
      if ({txValid, traceNext, inStatus, txWord} !== {eValid, eNext, eStat, eWord}) begin
        errors++; $display("FAIL status_first cyc %0d: got v%b n%b s%b w%h expected v%b n%b s%b w%h",
                           c, txValid, traceNext, inStatus, txWord, eValid, eNext, eStat, eWord);
      end
      if (txValid && txFree) begin words[n] = txWord; n++; end
      tick(); c++;
    end
    checks++; if (n != FL) begin errors++; $display("FAIL status_first_count: got %0d expected %0d", n, FL); end
    checks++; if (words[0] !== 16'hA55A) begin errors++; $display("FAIL status_w0: got %h expected A55A", words[0]); end
    checks++; if (words[1] !== 16'h8000) begin errors++; $display("FAIL status_w1: got %h expected 8000", words[1]); end
    checks++; if (words[2] !== 16'h0000) begin errors++; $display("FAIL status_w2: got %h expected 0000", words[2]); end
    checks++; if (words[3] !== 16'h0000) begin errors++; $display("FAIL status_w3: got %h expected 0000", words[3]); end
    for (int i = 4; i < FL; i++) begin
      checks++; if (words[i] !== 16'h0000) begin errors++; $display("FAIL status_pad%0d: got %h expected 0000", i, words[i]); end
    end
    waitModel(2, 3, "status_seq_wait");
    #1;
    checks++; if (txWord !== 16'h0001) begin errors++; $display("FAIL status_seq: got %h expected 0001", txWord); end
  endtask

  task automatic test_order();
    int kinds[4];
    int pulses[4];
    int f = 0, dN = 0, p = 0, c = 0;
    applyReset();
    traceAvail = 1; txFree = 1; sync = 0;
    while (f < 4 && c < 200) begin
      traceWd = 16'($urandom);
      #1; modelOut(); checks++;
      if ({txValid, traceNext, inStatus, txWord} !== {eValid, eNext, eStat, eWord}) begin
        errors++; $display("FAIL order cyc %0d: got v%b n%b s%b w%h expected v%b n%b s%b w%h",
                           c, txValid, traceNext, inStatus, txWord, eValid, eNext, eStat, eWord);
      end
      if (traceNext) p++;
      if (txValid && txFree) begin
        dN++;
        if (dN == FL) begin kinds[f] = int'(inStatus); pulses[f] = p; f++; dN = 0; p = 0; end
      end
      tick(); c++;
    end
    checks++; if (f != 4) begin errors++; $display("FAIL order_frames: got %0d expected 4", f); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (kinds[i] != ((i == 0 || i == 3) ? 1 : 0) || pulses[i] != ((i == 0 || i == 3) ? 0 : FL)) begin
        errors++; $display("FAIL order_frame%0d: got status=%0d pulses=%0d expected status=%0d pulses=%0d",
                           i, kinds[i], pulses[i], (i == 0 || i == 3) ? 1 : 0, (i == 0 || i == 3) ? 0 : FL);
      end
    end
  endtask

  task automatic test_stall();
    int drop = 0, tn = 0, zeroV = 0, c = 0;
    bit seen = 0;
    applyReset();
    txFree = 1; traceAvail = 1;
    while (c < 300 && !(seen && mKind != 1)) begin
      if (mKind == 1 && mIdx == 7 && drop < 5) begin traceAvail = 0; drop++; end
      else traceAvail = 1;
      traceWd = 16'($urandom);
      #1; modelOut(); checks++;
      if ({txValid, traceNext, inStatus, txWord} !== {eValid, eNext, eStat, eWord}) begin
        errors++; $display("FAIL stall cyc %0d: got v%b n%b s%b w%h expected v%b n%b s%b w%h",
                           c, txValid, traceNext, inStatus, txWord, eValid, eNext, eStat, eWord);
      end
      if (mKind == 1) begin
        seen = 1;
        if (traceNext) tn++;
        if (!txValid) zeroV++;
      end
      tick(); c++;
    end
    checks++; if (tn != FL) begin errors++; $display("FAIL stall_transfers: got %0d expected %0d", tn, FL); end
    checks++; if (zeroV != 5) begin errors++; $display("FAIL stall_gap: got %0d expected 5", zeroV); end
  endtask

  task automatic test_ovf();
    applyReset();
    txFree = 1;
    waitModel(2, 15, "ovf_first_frame");
    tick();
    txFree = 0;
    tick();
    for (int i = 0; i < 3; i++) begin ovf = 1; tick(); ovf = 0; tick(); end
    ovf = 1; txFree = 1;
    tick();
    ovf = 0;
    waitModel(2, 2, "ovf_w2_a");
    #1;
    checks++; if (txWord !== 16'h0003) begin errors++; $display("FAIL ovf_snap3: got %h expected 0003", txWord); end
    waitModel(2, 15, "ovf_end_a");
    tick();
    waitModel(2, 2, "ovf_w2_b");
    #1;
    checks++; if (txWord !== 16'h0001) begin errors++; $display("FAIL ovf_coincident: got %h expected 0001", txWord); end
    txFree = 0; ovf = 1;
    repeat (70000) tick();
    ovf = 0; txFree = 1;
    waitModel(2, 15, "ovf_end_b");
    tick();
    waitModel(2, 2, "ovf_w2_c");
    #1;
    checks++; if (txWord !== 16'hFFFF) begin errors++; $display("FAIL ovf_saturate: got %h expected FFFF", txWord); end
  endtask

  task automatic test_frame_reset();
    applyReset();
    txFree = 1; traceAvail = 1; traceWd = 16'($urandom);
    waitModel(1, 9, "fr_wait");
    frameReset = 1;
    #1;
    checks++; if (txValid !== 1'b0 || traceNext !== 1'b0)
      begin errors++; $display("FAIL fr_suppress: got v%b n%b expected v0 n0", txValid, traceNext); end
    tick(); #1;
    checks++; if (txValid !== 1'b0 || inStatus !== 1'b0)
      begin errors++; $display("FAIL fr_idle: got v%b s%b expected v0 s0", txValid, inStatus); end
    tick();
    frameReset = 0;
    #1;
    checks++; if (txValid !== 1'b0) begin errors++; $display("FAIL fr_decide: got v%b expected 0", txValid); end
    tick(); #1;
    checks++; if (inStatus !== 1'b1 || txWord !== 16'hA55A)
      begin errors++; $display("FAIL fr_status: got s%b w%h expected s1 wA55A", inStatus, txWord); end
    waitModel(2, 3, "fr_seq_wait");
    #1;
    checks++; if (txWord !== 16'h0001) begin errors++; $display("FAIL fr_seq: got %h expected 0001", txWord); end
  endtask

  task automatic test_txfree_toggle();
    logic [15:0] words[FL];
    logic [15:0] prevWord = 16'h0;
    logic prevHeld = 1'b0;
    int n = 0, c = 0;
    applyReset();
    traceAvail = 0; sync = 1;
    while (n < FL && c < 100) begin
      txFree = (c % 2 == 0);
      #1; modelOut(); checks++;
      if ({txValid, traceNext, inStatus, txWord} !== {eValid, eNext, eStat, eWord}) begin
        errors++; $display("FAIL toggle cyc %0d: got v%b n%b s%b w%h expected v%b n%b s%b w%h",
                           c, txValid, traceNext, inStatus, txWord, eValid, eNext, eStat, eWord);
      end
      if (prevHeld) begin
        checks++;
        if (txWord !== prevWord) begin errors++; $display("FAIL toggle_hold cyc %0d: got %h expected %h", c, txWord, prevWord); end
      end
      prevHeld = txValid && !txFree;
      prevWord = txWord;
      if (txValid && txFree) begin words[n] = txWord; n++; end
      tick(); c++;
    end
    checks++; if (n != FL) begin errors++; $display("FAIL toggle_count: got %0d expected %0d", n, FL); end
    for (int i = 0; i < FL; i++) begin
      logic [15:0] want;
      want = (i == 0) ? 16'hA55A : (i == 1) ? 16'h8000 : 16'h0000;
      checks++; if (words[i] !== want) begin errors++; $display("FAIL toggle_w%0d: got %h expected %h", i, words[i], want); end
    end
  endtask

  task automatic test_random();
    applyReset();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 399) != 0);
      traceAvail = ($urandom_range(0, 3) != 0);
      txFree     = ($urandom_range(0, 2) != 0);
      ovf        = ($urandom_range(0, 3) == 0);
      frameReset = ($urandom_range(0, 39) == 0);
      sync       = 1'($urandom);
      traceWd    = 16'($urandom);
      if (!rst) modelReset();
      #1; modelOut(); checks++;
      if ({txValid, traceNext, inStatus, txWord} !== {eValid, eNext, eStat, eWord}) begin
        errors++; $display("FAIL random cyc %0d: got v%b n%b s%b w%h expected v%b n%b s%b w%h",
                           c, txValid, traceNext, inStatus, txWord, eValid, eNext, eStat, eWord);
      end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    test_reset();
    test_status_first();
    test_order();
    test_stall();
    test_ovf();
    test_frame_reset();
    test_txfree_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
